// File: rtl/ct_f_spsram_pkg.sv
// Shared types and helpers for the single-port SRAM request controller.
// Holds the controller state encoding and the lane-mask to WEN expansion.
package ct_f_spsram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Upper bounds that let one helper serve any geometry; callers keep the low bits.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_LANES  = 64;

    // Active-high lane enables -> active-low per-bit WEN; bits past the word stay masked.
    function automatic logic [MAX_DATA_W-1:0] mask_to_wen(
        input logic [MAX_LANES-1:0] mask,
        input int                   lanes,
        input int                   lane_w
    );
        logic [MAX_DATA_W-1:0] wen;
        wen = '1;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < lanes * lane_w) begin
                wen[i] = ~mask[i / lane_w];
            end
        end
        return wen;
    endfunction

endpackage

// File: rtl/ct_f_spsram_req_ctrl_if.sv
// Request/response and init handshake between an array user and the SRAM controller.
// The master side is the array user; the slave side is the controller.
interface ct_f_spsram_req_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 104,
    parameter int LANES      = 4
);
    logic                  init_req;
    logic                  init_done;
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [LANES-1:0]      req_wmask;
    logic                  rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output init_req, req_vld, req_wr, req_addr, req_wdata, req_wmask,
        input  init_done, req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  init_req, req_vld, req_wr, req_addr, req_wdata, req_wmask,
        output init_done, req_rdy, rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/ct_f_spsram_req_ctrl.sv
// Initiator-side controller for a single-port SRAM macro: zero-fills the array after
// reset or on request, then serves masked writes and 1-cycle-latency reads.
module ct_f_spsram_req_ctrl
    import ct_f_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 104,
    parameter int LANE_W     = 26
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    ct_f_spsram_req_ctrl_if.slave req_if,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int LANES = DATA_WIDTH / LANE_W;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [DATA_WIDTH-1:0] rdata_hold;
    logic [MAX_DATA_W-1:0] wen_full;
    logic                  accept;

    assign req_if.req_rdy   = (state == RUN) && !req_if.init_req;
    assign accept           = req_if.req_vld && req_if.req_rdy;
    assign req_if.rsp_rdata = req_if.rsp_vld ? sram_q : rdata_hold;
    assign wen_full         = mask_to_wen(MAX_LANES'(req_if.req_wmask), LANES, LANE_W);

    // NOTE: every output gets an idle default first so no path leaves a latch behind.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        sram_a    = '0;
        if (state == INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_cnt;
        end else if (accept) begin
            sram_a = req_if.req_addr;
            if (req_if.req_wr) begin
                // An all-zero mask is still accepted but leaves the macro deselected.
                sram_cen  = ~|req_if.req_wmask;
                sram_gwen = ~|req_if.req_wmask;
                sram_wen  = wen_full[DATA_WIDTH-1:0];
                sram_d    = req_if.req_wdata;
            end else begin
                sram_cen = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state            <= INIT;
            init_cnt         <= '0;
            req_if.init_done <= 1'b0;
            req_if.rsp_vld   <= 1'b0;
            rdata_hold       <= '0;
        end else begin
            req_if.rsp_vld <= accept && !req_if.req_wr;
            if (req_if.rsp_vld) begin
                rdata_hold <= sram_q;
            end
            unique case (state)
                INIT: begin
                    if (req_if.init_req) begin
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                        if (init_cnt == '1) begin
                            state            <= RUN;
                            req_if.init_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (req_if.init_req) begin
                        state            <= INIT;
                        init_cnt         <= '0;
                        req_if.init_done <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: doc/ct_f_spsram_req_ctrl.md
Name: ct_f_spsram_req_ctrl

Overview:
- Initiator-side controller for the single-port FPGA SRAM wrappers; drives the active-low A/CEN/GWEN/WEN/D/Q macro interface.
- After reset, and on request, zero-fills the whole array.
- Afterwards accepts valid/ready read and write requests with lane write masks, and returns read data one cycle later.
- Sits between an L1/L2 array user and a ct_f_spsram_* instance.

Parameters:
- ADDR_WIDTH, 7, SRAM address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 104, SRAM word width.
- LANE_W, 26, write-mask granularity; DATA_WIDTH must be a multiple of LANE_W; LANES = DATA_WIDTH/LANE_W.

Ports:
- forever_cpuclk  in  1  clock; all state on rising edge
- cpurst_b  in  1  asynchronous reset, active-low
- init_req  in  1  pulse: re-zero the array
- init_done  out  1  high when array initialised and controller in RUN
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld&&req_rdy
- req_wr  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  LANES  active-high lane write enable
- rsp_vld  out  1  one-cycle pulse: read data valid
- rsp_rdata  out  DATA_WIDTH  read data
- sram_a  out  ADDR_WIDTH  to SRAM A
- sram_cen  out  1  to SRAM CEN (active-low)
- sram_gwen  out  1  to SRAM GWEN (active-low)
- sram_wen  out  DATA_WIDTH  to SRAM WEN (active-low bit mask)
- sram_d  out  DATA_WIDTH  to SRAM D
- sram_q  in  DATA_WIDTH  from SRAM Q

Behaviour:
- FSM states: INIT, RUN. Reset enters INIT with init_cnt=0.
- Reset values: init_done=0, rsp_vld=0, rdata_hold=0, req_rdy=0.
- INIT, each cycle:
  - Drives sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=init_cnt; then init_cnt++.
  - When init_cnt==DEPTH-1 is written, next state is RUN. The counter wraps to 0.
  - INIT therefore lasts exactly DEPTH cycles; init_done rises on the following cycle.
- RUN:
  - req_rdy = 1 unless init_req=1 in the same cycle. init_req wins: the request is not accepted, and the next state is INIT with init_cnt=0.
  - init_req during INIT restarts the count at 0.
- Accepted request: SRAM pins driven combinationally in the same cycle.
  - sram_cen = 0 and sram_a = req_addr.
  - Read: sram_gwen=1, sram_wen=all 1.
  - Write: sram_d = req_wdata; sram_wen lane bits [k*LANE_W +: LANE_W] = {LANE_W{~req_wmask[k]}}; sram_gwen = ~|req_wmask.
  - Write with req_wmask==0: accepted, sram_cen stays 1, no SRAM access.
- Idle (no accept, RUN): sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_d=0, sram_a=0. The macro holds its last address internally.
- Read latency is 1. A read accepted at cycle t gives rsp_vld=1 at t+1, with rsp_rdata=sram_q. rdata_hold is loaded from sram_q at that edge.
- When rsp_vld=0, rsp_rdata=rdata_hold, so data stays stable until the next read response.
- Back-to-back reads are supported: one per cycle, with responses in order, one per cycle.
- Write followed by a read of the same address in the next cycle returns the new data, because the SRAM writes at edge t.
- No response backpressure: the consumer must take rsp_vld when it arrives.
- Async reset assertion mid-INIT or mid-read drops rsp_vld and any pending response, and restarts INIT.

Decomposition:
- Package ct_f_spsram_pkg holds:
  - FSM state enum (INIT, RUN).
  - Helper function expanding an LANES-bit mask to a DATA_WIDTH active-low WEN.
- No sub-module; init counter and FSM are inline.

Test Plan:
- Reset release, DEPTH=128 → sram_cen=0 for exactly 128 cycles, addresses 0..127, D=0, WEN=0; init_done=1 on cycle 129; reading addr 0x55 then returns 0.
- Write 0x55 with data 104'hA5…A5 and mask 4'b1111, then read 0x55 → rsp_vld one cycle after the read accept, rsp_rdata=A5…A5; rsp_rdata still A5…A5 five cycles later.
- Write addr 3 with all-ones data and mask 4'b0101 onto zeroed data → sram_wen lanes 0 and 2 = 0; read returns bits [25:0] and [77:52] set, others 0.
- Write with mask 0 → req_rdy=1, sram_cen stays 1, memory unchanged.
- Reads to 1, 2, 3 on consecutive cycles → three consecutive rsp_vld pulses, data in order.
- init_req with req_vld in the same RUN cycle → req_rdy=0, INIT restarts at addr 0, init_done drops; cpurst_b pulse at init_cnt=60 → INIT restarts from 0.
